// File: rtl/clock_div_multi.sv
// clock_div_multi: NUM_CH independent square-wave clock-enables derived from
// sys_clk. Each channel has a programmable half-period, a level enable and a
// registered one-cycle tick on every rising edge of its square wave. A global
// debug level speeds every counter up by DEBUG_STEP, and a sync strobe
// realigns the phase of all channels.
module clock_div_multi #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 26,
   parameter int RESET_HALF = 25000000,
   parameter int DEBUG_STEP = 10,
   parameter int CH_W       = 2
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              debug_signal,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(RESET_HALF);
   // Sums carry one extra bit so cnt+step never wraps before the compare.
   localparam logic [CNT_W:0]   STEP_DBG = (CNT_W+1)'(DEBUG_STEP);
   localparam logic [CNT_W:0]   STEP_ONE = (CNT_W+1)'(1);

   logic [CNT_W-1:0]  half_q [NUM_CH];
   logic [CNT_W-1:0]  half_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  cnt_d  [NUM_CH];
   logic [CNT_W:0]    sum_w  [NUM_CH];
   logic [NUM_CH-1:0] clk_q;
   logic [NUM_CH-1:0] clk_d;
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] tick_d;
   logic [CNT_W:0]    step_w;

   // Per-cycle increment; a debug change simply alters the next increment.
   always_comb begin
      step_w = debug_signal ? STEP_DBG : STEP_ONE;
   end

   // Half-period registers; out-of-range channel indices match no channel
   // and are therefore ignored. A write does not disturb cnt or the phase.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         half_d[i] = half_q[i];
         if (cfg_wr && (cfg_ch == CH_W'(i))) begin
            half_d[i] = cfg_half;
         end
      end
   end

   // Per-channel counter and square wave, priority sync > disable > parked
   // (half==0) > counting. Compare is >= so a half shrunk below the running
   // count toggles on the next cycle instead of wrapping the counter.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sum_w[i] = {1'b0, cnt_q[i]} + step_w;
         cnt_d[i] = cnt_q[i];
         clk_d[i] = clk_q[i];
         if (sync) begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
         end else if (!ch_en[i] || (half_q[i] == '0)) begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
         end else if (sum_w[i] >= {1'b0, half_q[i]}) begin
            cnt_d[i] = '0;
            clk_d[i] = ~clk_q[i];
         end else begin
            cnt_d[i] = sum_w[i][CNT_W-1:0];
         end
      end
   end

   // Tick marks the cycle in which the registered wave first reads high.
   always_comb begin
      tick_d = clk_d & ~clk_q;
   end

   // State registers; reset restores the power-on half-period as well.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            half_q[i] <= HALF_RST;
            cnt_q[i]  <= '0;
         end
         clk_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            half_q[i] <= half_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;

endmodule

// File: tb/tb_clock_div_multi.sv
// Scoreboard bench for clock_div_multi: the stimulus process pushes
// hand-derived expected (clk_out, tick) values tagged with the cycle they
// apply to; a negedge monitor pops and compares them.
module tb_clock_div_multi;

   localparam int CNT_W = 8;

   logic             sys_clk;
   logic             reset_n;
   logic             debug_signal;
   logic [3:0]       ch_en;
   logic             sync;
   logic             cfg_wr;
   logic [1:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_wr3;
   logic [1:0]       cfg_ch3;
   logic [CNT_W-1:0] cfg_half3;
   logic [3:0]       clk4, tick4;
   logic [2:0]       clk3, tick3;

   clock_div_multi #(.NUM_CH(4), .CNT_W(CNT_W), .RESET_HALF(5), .DEBUG_STEP(2), .CH_W(2)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .debug_signal(debug_signal), .ch_en(ch_en),
      .sync(sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
      .clk_out(clk4), .tick(tick4));

   clock_div_multi #(.NUM_CH(3), .CNT_W(CNT_W), .RESET_HALF(5), .DEBUG_STEP(2), .CH_W(2)) dut3 (
      .sys_clk(sys_clk), .reset_n(reset_n), .debug_signal(debug_signal), .ch_en(ch_en[2:0]),
      .sync(sync), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3), .cfg_half(cfg_half3),
      .clk_out(clk3), .tick(tick3));

   typedef struct {
      int cyc;
      bit d3;
      int ch;
      bit clk;
      bit tk;
   } exp_t;

   exp_t sbq[$];
   int   cyc;
   int   n_cmp;
   int   n_err;

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d required end of stimulus", cyc);
      $fatal(1, "watchdog");
   end

   // Monitor: compare every queued expectation for the current cycle.
   always @(negedge sys_clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc == cyc) begin
            exp_t e;
            bit a_clk, a_tk;
            e = sbq[i];
            a_clk = e.d3 ? clk3[e.ch] : clk4[e.ch];
            a_tk  = e.d3 ? tick3[e.ch] : tick4[e.ch];
            n_cmp++;
            if (a_clk !== e.clk || a_tk !== e.tk) begin
               n_err++;
               $display("FAIL %s ch%0d cyc%0d: got clk_out=%0b tick=%0b, expected clk_out=%0b tick=%0b",
                        e.d3 ? "dut3" : "dut4", e.ch, cyc, a_clk, a_tk, e.clk, e.tk);
            end
            sbq.delete(i);
         end else if (sbq[i].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL expired %s ch%0d: entry for cyc%0d never compared, now cyc%0d",
                     sbq[i].d3 ? "dut3" : "dut4", sbq[i].ch, sbq[i].cyc, cyc);
            sbq.delete(i);
         end
      end
   end

   task automatic push(input bit d3, input int ch, input int c, input bit clk, input bit tk);
      exp_t e;
      e.cyc = c; e.d3 = d3; e.ch = ch; e.clk = clk; e.tk = tk;
      sbq.push_back(e);
   endtask

   // Clean-phase run: state (cnt=0, clk=0) after cycle 'start', half h.
   task automatic exp_run(input bit d3, input int ch, input int start, input int h,
                          input int j0, input int j1);
      for (int j = j0; j <= j1; j++)
         push(d3, ch, start + j, ((j / h) % 2) == 1, (j % (2 * h)) == h);
   endtask

   task automatic exp_low(input bit d3, input int ch, input int c0, input int c1);
      for (int c = c0; c <= c1; c++) push(d3, ch, c, 1'b0, 1'b0);
   endtask

   task automatic exp_zero_all(input int c);
      for (int k = 0; k < 4; k++) push(1'b0, k, c, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) push(1'b1, k, c, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) step();
   endtask

   initial begin
      int s;
      reset_n = 1'b0; debug_signal = 1'b0; ch_en = 4'hF; sync = 1'b0;
      cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0;
      cfg_wr3 = 1'b0; cfg_ch3 = '0; cfg_half3 = '0;
      repeat (3) step();
      exp_zero_all(0);
      step();
      reset_n = 1'b1;

      // Reset halves of 5: period 10, all channels in phase.
      for (int k = 0; k < 4; k++) exp_run(1'b0, k, 0, 5, 1, 20);
      for (int k = 0; k < 3; k++) exp_run(1'b1, k, 0, 5, 1, 20);
      wait_until(20);

      // ch1 half 2, ch2 half 1, then realign.
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd2;
      step();
      cfg_ch = 2'd2; cfg_half = 8'd1;
      step();
      cfg_wr = 1'b0; sync = 1'b1;
      s = cyc + 1;
      exp_run(1'b0, 0, s, 5, 0, 20);
      exp_run(1'b0, 1, s, 2, 0, 20);
      exp_run(1'b0, 2, s, 1, 0, 20);
      exp_run(1'b0, 3, s, 5, 0, 20);
      step();
      sync = 1'b0;
      wait_until(s + 20);

      // Debug step 2: ch3 (half 5) toggles every 3 cycles; drop debug at cnt=2.
      sync = 1'b1; debug_signal = 1'b1;
      s = cyc + 1;
      exp_run(1'b0, 3, s, 3, 0, 7);
      exp_low(1'b0, 3, s + 8, s + 9);
      exp_run(1'b0, 3, s + 5, 5, 5, 20);
      exp_run(1'b0, 1, s, 1, 0, 7);
      step();
      sync = 1'b0;
      wait_until(s + 7);
      debug_signal = 1'b0;
      wait_until(s + 25);

      // Shrink half below running count; out-of-range write on 3-channel dut.
      sync = 1'b1;
      s = cyc + 1;
      exp_low(1'b0, 3, s, s + 2);
      exp_run(1'b0, 3, s + 1, 2, 2, 12);
      exp_run(1'b0, 0, s, 5, 0, 4);
      exp_run(1'b0, 0, s + 2, 3, 3, 15);
      for (int k = 0; k < 3; k++) exp_run(1'b1, k, s, 5, 0, 15);
      step();
      sync = 1'b0;
      step();
      cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd2;
      cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_half3 = 8'd1;
      step();
      cfg_wr = 1'b0; cfg_wr3 = 1'b0;
      step();
      cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3;
      step();
      cfg_wr = 1'b0;
      wait_until(s + 17);

      // sync with cfg_wr(ch0,7); then disable ch0 while high, park ch1.
      sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd7;
      s = cyc + 1;
      exp_run(1'b0, 0, s, 7, 0, 9);
      exp_low(1'b0, 0, s + 10, s + 13);
      exp_run(1'b0, 0, s + 14, 7, 0, 16);
      exp_run(1'b0, 1, s, 2, 0, 3);
      exp_low(1'b0, 1, s + 4, s + 30);
      exp_run(1'b0, 2, s, 1, 0, 30);
      exp_run(1'b0, 3, s, 2, 0, 30);
      step();
      sync = 1'b0; cfg_wr = 1'b0;
      wait_until(s + 2);
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd0;
      step();
      cfg_wr = 1'b0;
      wait_until(s + 9);
      ch_en[0] = 1'b0;
      wait_until(s + 14);
      ch_en[0] = 1'b1;
      wait_until(s + 31);

      // Async reset mid-cycle while ch2 is high; halves return to 5.
      #2;
      exp_zero_all(0);
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) exp_run(1'b0, k, 0, 5, 1, 20);
      for (int k = 0; k < 3; k++) exp_run(1'b1, k, 0, 5, 1, 20);
      wait_until(21);

      n_cmp++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL leftover: %0d expectations never compared, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised multi-channel successor to the single-rate 1 s / 0.5 s divider; generates NUM_CH independent square-wave clock-enables from sys_clk.
- Each channel has a runtime-programmable half-period, an enable, and a single-cycle rising-edge tick.
- Global debug speed-up and phase-sync strobe.
- Feeds the clock's time-keeping counters and blink logic.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 26, width of half-period registers and counters.
- RESET_HALF, 25000000, half-period loaded into every channel at reset (1 Hz at 50 MHz).
- DEBUG_STEP, 10, counter increment while debug_signal=1 (normal increment is 1).
- CH_W, 2, width of cfg_ch; must satisfy 2^CH_W >= NUM_CH.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- debug_signal  input  1  level; 1 = counters advance by DEBUG_STEP per cycle.
- ch_en  input  NUM_CH  per-channel enable, level.
- sync  input  1  one-cycle strobe; realigns phase of all channels.
- cfg_wr  input  1  one-cycle write strobe for half-period register.
- cfg_ch  input  CH_W  channel index for cfg_wr.
- cfg_half  input  CNT_W  new half-period in sys_clk cycles (normal mode).
- clk_out  output  NUM_CH  per-channel square wave, registered.
- tick  output  NUM_CH  one-cycle pulse coincident with each 0->1 transition of clk_out, registered.

Behaviour:
- Reset (async assert, sync release by design): every half[i]=RESET_HALF, cnt[i]=0, clk_out=0, tick=0.
- Per channel, priority per cycle: sync > !ch_en[i] > half[i]==0 > counting.
- sync=1: all cnt=0, clk_out=0, tick=0 next cycle, regardless of ch_en.
- ch_en[i]=0: cnt[i] held at 0, clk_out[i]=0, tick[i]=0. On re-enable, counting resumes from 0 with clk_out low.
- half[i]==0: channel parked as if disabled (no toggles, no ticks).
- Counting: step = DEBUG_STEP if debug_signal else 1. Sum = cnt[i]+step, computed in CNT_W+1 bits (no wrap).
  - If sum >= half[i]: cnt[i]<=0 and clk_out[i] toggles.
  - Else cnt[i]<=sum[CNT_W-1:0].
- tick[i]=1 for exactly the cycle in which clk_out[i] is 1 after being 0 the previous cycle. tick=0 on every other cycle, including the toggle to 0.
- Period in normal mode = 2*half[i] cycles; half=1 gives clk_out = sys_clk/2 and a tick every 2 cycles.
- Debug mode: half-period = ceil(half[i]/DEBUG_STEP) cycles. Toggling debug_signal mid-count takes effect on the next increment; cnt is not cleared.
- Config write: cfg_wr=1 with cfg_ch<NUM_CH loads half[cfg_ch]<=cfg_half at that edge.
  - The comparison uses the new value from the following cycle.
  - cnt is not cleared. If cnt+step already >= new half, the channel toggles on the next cycle (no long wrap).
- cfg_ch >= NUM_CH: write ignored, no state changes.
- cfg_wr and sync in the same cycle: both take effect; half updated and all phases cleared.
- Outputs are pure registers; no combinational path from inputs to outputs.
- Reset asserted mid-count: immediate return to reset values, including half registers.

Test Plan:
- Reset, NUM_CH=4, RESET_HALF=5, all ch_en=1 -> each clk_out toggles every 5 cycles (period 10); tick pulses once per 10 cycles, aligned with the 0->1 edge; all channels in phase.
- Write cfg_ch=1, cfg_half=2; then cfg_ch=2, cfg_half=1 -> ch1 period 4, ch2 period 2 (tick every 2 cycles); ch0 and ch3 unchanged at 10.
- Set half=5 on ch3, debug_signal=1, DEBUG_STEP=2 -> ch3 toggles every 3 cycles; drop debug_signal mid-count -> resumes step 1 without clearing cnt.
- At cnt=4 of half=5, write cfg_half=3 -> toggle on the next cycle. Write cfg_ch=3 when NUM_CH=3 -> no half register changes.
- Let channels drift with differing halves, pulse sync together with cfg_wr(ch0, 7) -> all clk_out=0 and cnt=0 next cycle; ch0 then runs period 14 and others restart aligned.
- Deassert ch_en[0] while clk_out[0]=1 -> clk_out[0]=0 and no tick next cycle. Write half=0 to ch1 -> ch1 stays low. Assert reset_n low asynchronously mid-cycle -> all outputs 0 immediately and halves back to RESET_HALF.
